// File: rtl/div_arbiter.sv
// div_arbiter: lets two requesters (A and B) share one external divider.
// Each port latches its own request, a round-robin FSM issues one request
// at a time, and the divider's answer is routed back to the port that owns it.
module div_arbiter #(
    parameter int BW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,

    input  logic          i_a_wr,
    input  logic          i_b_wr,
    input  logic          i_a_signed,
    input  logic          i_b_signed,
    input  logic [BW-1:0] i_a_numerator,
    input  logic [BW-1:0] i_a_denominator,
    input  logic [BW-1:0] i_b_numerator,
    input  logic [BW-1:0] i_b_denominator,

    output logic          o_a_busy,
    output logic          o_b_busy,
    output logic          o_a_valid,
    output logic          o_b_valid,
    output logic          o_a_err,
    output logic          o_b_err,
    output logic [BW-1:0] o_a_quotient,
    output logic [BW-1:0] o_b_quotient,
    output logic [3:0]    o_a_flags,
    output logic [3:0]    o_b_flags,

    output logic          o_div_wr,
    output logic          o_div_signed,
    output logic [BW-1:0] o_div_numerator,
    output logic [BW-1:0] o_div_denominator,

    input  logic          i_div_busy,
    input  logic          i_div_valid,
    input  logic          i_div_err,
    input  logic [BW-1:0] i_div_quotient,
    input  logic [3:0]    i_div_flags,

    output logic          o_grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;       // 0 = A, 1 = B
    logic          prio_b_q, prio_b_d;     // 1 when B wins a tie
    logic          div_signed_q, div_signed_d;
    logic [BW-1:0] div_num_q, div_num_d;
    logic [BW-1:0] div_den_q, div_den_d;

    // Requester inputs gathered into index-by-port form (0 = A, 1 = B)
    logic [1:0]    req_wr;
    logic [1:0]    req_signed;
    logic [BW-1:0] req_num [2];
    logic [BW-1:0] req_den [2];

    // Per-port state exported from the port slices
    logic [1:0]    pend;
    logic [1:0]    lat_signed;
    logic [BW-1:0] lat_num [2];
    logic [BW-1:0] lat_den [2];
    logic [1:0]    deliver;
    logic [1:0]    res_valid;
    logic [1:0]    res_err;
    logic [BW-1:0] res_quo [2];
    logic [3:0]    res_flags [2];

    // Divider answer accepted this cycle; only meaningful while waiting on it
    logic          complete;

    assign req_wr     = {i_b_wr, i_a_wr};
    assign req_signed = {i_b_signed, i_a_signed};
    assign req_num[0] = i_a_numerator;
    assign req_num[1] = i_b_numerator;
    assign req_den[0] = i_a_denominator;
    assign req_den[1] = i_b_denominator;

    assign complete = (state_q == ST_WAIT) && i_div_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT = (gi == 1);

            logic          pend_q;
            logic          signed_q;
            logic [BW-1:0] num_q;
            logic [BW-1:0] den_q;
            logic          valid_q;
            logic          err_q;
            logic [BW-1:0] quo_q;
            logic [3:0]    flags_q;

            assign deliver[gi] = complete && (owner_q == PORT);

            // Request latch: accept only when idle, drop pending on delivery
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    pend_q   <= 1'b0;
                    signed_q <= 1'b0;
                    num_q    <= '0;
                    den_q    <= '0;
                end else if (deliver[gi]) begin
                    pend_q   <= 1'b0;
                end else if (req_wr[gi] && !pend_q) begin
                    pend_q   <= 1'b1;
                    signed_q <= req_signed[gi];
                    num_q    <= req_num[gi];
                    den_q    <= req_den[gi];
                end
            end

            // Result registers: one-cycle strobe, data held until next delivery
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    quo_q   <= '0;
                    flags_q <= '0;
                end else begin
                    valid_q <= deliver[gi];
                    if (deliver[gi]) begin
                        err_q   <= i_div_err;
                        quo_q   <= i_div_quotient;
                        flags_q <= i_div_flags;
                    end
                end
            end

            assign pend[gi]       = pend_q;
            assign lat_signed[gi] = signed_q;
            assign lat_num[gi]    = num_q;
            assign lat_den[gi]    = den_q;
            assign res_valid[gi]  = valid_q;
            assign res_err[gi]    = err_q;
            assign res_quo[gi]    = quo_q;
            assign res_flags[gi]  = flags_q;
        end
    endgenerate

    // Arbiter state, owner, tie-break pointer and divider operand registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            prio_b_q     <= 1'b0;
            div_signed_q <= 1'b0;
            div_num_q    <= '0;
            div_den_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            prio_b_q     <= prio_b_d;
            div_signed_q <= div_signed_d;
            div_num_q    <= div_num_d;
            div_den_q    <= div_den_d;
        end
    end

    // Next-state: pick an owner when the divider is free, issue once, wait for it
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        prio_b_d     = prio_b_q;
        div_signed_d = div_signed_q;
        div_num_d    = div_num_q;
        div_den_d    = div_den_q;

        case (state_q)
            ST_IDLE: begin
                if ((pend != 2'b00) && !i_div_busy) begin
                    if (pend == 2'b11) begin
                        owner_d = prio_b_q;
                    end else begin
                        owner_d = pend[1];
                    end
                    div_signed_d = lat_signed[owner_d];
                    div_num_d    = lat_num[owner_d];
                    div_den_d    = lat_den[owner_d];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_div_valid) begin
                    // The port just served yields the next tie
                    prio_b_d = ~owner_q;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_div_wr          = (state_q == ST_ISSUE);
    assign o_div_signed      = div_signed_q;
    assign o_div_numerator   = div_num_q;
    assign o_div_denominator = div_den_q;
    assign o_grant           = owner_q;

    assign o_a_busy     = pend[0];
    assign o_b_busy     = pend[1];
    assign o_a_valid    = res_valid[0];
    assign o_b_valid    = res_valid[1];
    assign o_a_err      = res_err[0];
    assign o_b_err      = res_err[1];
    assign o_a_quotient = res_quo[0];
    assign o_b_quotient = res_quo[1];
    assign o_a_flags    = res_flags[0];
    assign o_b_flags    = res_flags[1];

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed vectors with a result scoreboard, an issue
// scoreboard checked by a behavioural divider, and a decoupled output monitor.
`timescale 1ns/1ps
module tb_div_arbiter;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_a_wr, i_b_wr, i_a_signed, i_b_signed;
    logic [BW-1:0] i_a_numerator, i_a_denominator, i_b_numerator, i_b_denominator;
    logic          o_a_busy, o_b_busy, o_a_valid, o_b_valid, o_a_err, o_b_err;
    logic [BW-1:0] o_a_quotient, o_b_quotient;
    logic [3:0]    o_a_flags, o_b_flags;
    logic          o_div_wr, o_div_signed;
    logic [BW-1:0] o_div_numerator, o_div_denominator;
    logic          i_div_busy, i_div_valid, i_div_err;
    logic [BW-1:0] i_div_quotient;
    logic [3:0]    i_div_flags;
    logic          o_grant;

    always #5 clk = ~clk;

    div_arbiter #(.BW(BW)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_a_wr(i_a_wr), .i_b_wr(i_b_wr),
        .i_a_signed(i_a_signed), .i_b_signed(i_b_signed),
        .i_a_numerator(i_a_numerator), .i_a_denominator(i_a_denominator),
        .i_b_numerator(i_b_numerator), .i_b_denominator(i_b_denominator),
        .o_a_busy(o_a_busy), .o_b_busy(o_b_busy),
        .o_a_valid(o_a_valid), .o_b_valid(o_b_valid),
        .o_a_err(o_a_err), .o_b_err(o_b_err),
        .o_a_quotient(o_a_quotient), .o_b_quotient(o_b_quotient),
        .o_a_flags(o_a_flags), .o_b_flags(o_b_flags),
        .o_div_wr(o_div_wr), .o_div_signed(o_div_signed),
        .o_div_numerator(o_div_numerator), .o_div_denominator(o_div_denominator),
        .i_div_busy(i_div_busy), .i_div_valid(i_div_valid), .i_div_err(i_div_err),
        .i_div_quotient(i_div_quotient), .i_div_flags(i_div_flags),
        .o_grant(o_grant)
    );

    typedef struct {
        logic        port;
        logic [31:0] q;
        logic        err;
        logic [3:0]  flags;
        int          t_wr;   // cycle of the strobe, -1 when latency is not checked
        int          lat;
    } res_t;

    typedef struct {
        logic        grant;
        logic        sgn;
        logic [31:0] num;
        logic [31:0] den;
    } iss_t;

    res_t exp_q[$];
    iss_t iss_q[$];

    int tests      = 0;
    int fails      = 0;
    int cyc        = 0;
    int div_delay  = 3;
    int div_wr_cnt = 0;
    bit reset_hit  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end else begin
            $display("[TB] ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic exp_res(input logic p, input logic [31:0] q, input logic e,
                           input logic [3:0] f, input int t, input int lat);
        res_t r;
        r.port = p; r.q = q; r.err = e; r.flags = f; r.t_wr = t; r.lat = lat;
        exp_q.push_back(r);
    endtask

    task automatic exp_iss(input logic g, input logic s, input logic [31:0] n, input logic [31:0] d);
        iss_t x;
        x.grant = g; x.sgn = s; x.num = n; x.den = d;
        iss_q.push_back(x);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put_a(input logic s, input logic [31:0] n, input logic [31:0] d);
        i_a_wr = 1'b1; i_a_signed = s; i_a_numerator = n; i_a_denominator = d;
    endtask

    task automatic put_b(input logic s, input logic [31:0] n, input logic [31:0] d);
        i_b_wr = 1'b1; i_b_signed = s; i_b_numerator = n; i_b_denominator = d;
    endtask

    task automatic clear_wr();
        i_a_wr = 1'b0; i_b_wr = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        bit done = 1'b0;
        for (int k = 0; k < bound && !done; k++) begin
            tick();
            if (exp_q.size() == 0 && iss_q.size() == 0 && !o_a_busy && !o_b_busy && !i_div_busy)
                done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL drain_timeout: %0d results and %0d issues still outstanding after %0d cycles",
                     exp_q.size(), iss_q.size(), bound);
        end
    endtask

    // Output monitor: every strobe is popped from the result scoreboard
    res_t mon_r;
    always @(negedge clk) begin
        if (!i_reset && (o_a_valid || o_b_valid)) begin
            check("valid_exclusive", 32'(o_a_valid & o_b_valid), 32'd0);
            check("valid_busy_exclusive", 32'((o_a_valid & o_a_busy) | (o_b_valid & o_b_busy)), 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: a_valid=%0b b_valid=%0b, required no strobe",
                         o_a_valid, o_b_valid);
            end else begin
                mon_r = exp_q.pop_front();
                check("result_port", 32'(o_b_valid), 32'(mon_r.port));
                if (o_b_valid) begin
                    check("b_quotient", o_b_quotient, mon_r.q);
                    check("b_err", 32'(o_b_err), 32'(mon_r.err));
                    check("b_flags", 32'(o_b_flags), 32'(mon_r.flags));
                end else begin
                    check("a_quotient", o_a_quotient, mon_r.q);
                    check("a_err", 32'(o_a_err), 32'(mon_r.err));
                    check("a_flags", 32'(o_a_flags), 32'(mon_r.flags));
                end
                if (mon_r.t_wr >= 0)
                    check("latency", 32'(cyc - mon_r.t_wr), 32'(mon_r.lat));
            end
        end
    end

    // Behavioural divider: checks each issue, answers div_delay cycles later
    iss_t              ie;
    logic              d_sgn;
    logic [31:0]       d_num, d_den, d_q;
    logic signed [31:0] s_num, s_den;
    logic              d_err;
    int                d_lat;
    initial begin
        i_div_busy = 1'b0; i_div_valid = 1'b0; i_div_err = 1'b0;
        i_div_quotient = '0; i_div_flags = '0;
        forever begin
            @(negedge clk);
            if (!i_reset && o_div_wr) begin
                div_wr_cnt++;
                check("div_wr_while_busy", 32'(i_div_busy), 32'd0);
                if (iss_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_issue: grant=%0b num=0x%08h, required no issue",
                             o_grant, o_div_numerator);
                end else begin
                    ie = iss_q.pop_front();
                    check("issue_grant", 32'(o_grant), 32'(ie.grant));
                    check("issue_signed", 32'(o_div_signed), 32'(ie.sgn));
                    check("issue_num", o_div_numerator, ie.num);
                    check("issue_den", o_div_denominator, ie.den);
                end
                d_sgn = o_div_signed; d_num = o_div_numerator; d_den = o_div_denominator;
                d_lat = div_delay;
                reset_hit = 1'b0;
                i_div_busy = 1'b1;
                @(negedge clk);
                check("div_wr_one_cycle", 32'(o_div_wr), 32'd0);
                repeat (d_lat - 1) @(negedge clk);
                if (!reset_hit) begin
                    check("div_num_stable", o_div_numerator, d_num);
                    check("div_den_stable", o_div_denominator, d_den);
                end
                if (d_den == 32'd0) begin
                    d_err = 1'b1; d_q = 32'd0;
                end else if (d_sgn) begin
                    d_err = 1'b0; s_num = d_num; s_den = d_den; d_q = s_num / s_den;
                end else begin
                    d_err = 1'b0; d_q = d_num / d_den;
                end
                i_div_quotient = d_q;
                i_div_err      = d_err;
                i_div_flags    = {d_sgn, d_err, (d_q == 32'd0), d_q[31]};
                i_div_valid    = 1'b1;
                i_div_busy     = 1'b0;
                @(negedge clk);
                i_div_valid = 1'b0;
                i_div_err   = 1'b0;
            end
        end
    end

    // Directed stimulus
    int  cnt0;
    bit  got;
    initial begin
        i_reset = 1'b1;
        i_a_wr = 1'b0; i_b_wr = 1'b0; i_a_signed = 1'b0; i_b_signed = 1'b0;
        i_a_numerator = '0; i_a_denominator = '0; i_b_numerator = '0; i_b_denominator = '0;
        repeat (2) tick();

        // Reset state
        check("rst_a_busy", 32'(o_a_busy), 32'd0);
        check("rst_b_busy", 32'(o_b_busy), 32'd0);
        check("rst_valids", 32'({o_a_valid, o_b_valid}), 32'd0);
        check("rst_div_wr", 32'(o_div_wr), 32'd0);
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_a_quotient", o_a_quotient, 32'd0);
        check("rst_b_flags", 32'(o_b_flags), 32'd0);
        i_reset = 1'b0;
        tick();

        // Both requesters in the same cycle: A first (fresh pointer), then B
        div_delay = 3;
        exp_iss(1'b0, 1'b0, 32'd100, 32'd7);
        exp_iss(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7);
        exp_res(1'b0, 32'd14, 1'b0, 4'b0000, -1, 0);
        exp_res(1'b1, 32'hFFFF_FFF2, 1'b0, 4'b1001, -1, 0);
        put_a(1'b0, 32'd100, 32'd7);
        put_b(1'b1, 32'hFFFF_FF9C, 32'd7);
        tick();
        clear_wr();
        check("both_busy", 32'({o_a_busy, o_b_busy}), 32'd3);
        wait_drain(60);
        check("grant_after_pair", 32'(o_grant), 32'd1);

        // A alone, minimum latency D+3 with D=3
        cnt0 = div_wr_cnt;
        exp_iss(1'b0, 1'b0, 32'd100, 32'd7);
        exp_res(1'b0, 32'd14, 1'b0, 4'b0000, cyc, 6);
        put_a(1'b0, 32'd100, 32'd7);
        tick();
        clear_wr();
        wait_drain(60);
        check("div_wr_count_single", 32'(div_wr_cnt - cnt0), 32'd1);
        check("b_quotient_held", o_b_quotient, 32'hFFFF_FFF2);
        check("grant_after_single", 32'(o_grant), 32'd0);

        // A re-requests on its strobe cycle while B is pending: B goes first
        div_delay = 5;
        exp_iss(1'b0, 1'b0, 32'd81, 32'd9);
        exp_iss(1'b1, 1'b0, 32'd64, 32'd8);
        exp_iss(1'b0, 1'b0, 32'd49, 32'd7);
        exp_res(1'b0, 32'd9, 1'b0, 4'b0000, -1, 0);
        exp_res(1'b1, 32'd8, 1'b0, 4'b0000, -1, 0);
        exp_res(1'b0, 32'd7, 1'b0, 4'b0000, -1, 0);
        put_a(1'b0, 32'd81, 32'd9);
        tick();
        clear_wr();
        repeat (2) tick();
        put_b(1'b0, 32'd64, 32'd8);
        tick();
        clear_wr();
        check("ignored_wr_keeps_busy", 32'(o_a_busy), 32'd1);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (o_a_valid) got = 1'b1;
        end
        check("a_valid_seen", 32'(got), 32'd1);
        check("a_busy_on_valid", 32'(o_a_busy), 32'd0);
        put_a(1'b0, 32'd49, 32'd7);
        tick();
        clear_wr();
        wait_drain(100);

        // B divides by zero: error reported on B, A outputs untouched
        div_delay = 3;
        exp_iss(1'b1, 1'b0, 32'd5, 32'd0);
        exp_res(1'b1, 32'd0, 1'b1, 4'b0110, -1, 0);
        put_b(1'b0, 32'd5, 32'd0);
        tick();
        clear_wr();
        wait_drain(60);
        check("a_quotient_held", o_a_quotient, 32'd7);
        check("a_err_held", 32'(o_a_err), 32'd0);
        check("b_err_held", 32'(o_b_err), 32'd1);
        check("b_flags_held", 32'(o_b_flags), 32'd6);

        // Reset while A is waiting on the divider; late answer must be dropped
        div_delay = 8;
        exp_iss(1'b0, 1'b0, 32'd50, 32'd5);
        put_a(1'b0, 32'd50, 32'd5);
        tick();
        clear_wr();
        repeat (4) tick();
        check("a_busy_pre_reset", 32'(o_a_busy), 32'd1);
        reset_hit = 1'b1;
        i_reset   = 1'b1;
        #1;
        check("mid_rst_a_busy", 32'(o_a_busy), 32'd0);
        check("mid_rst_a_quotient", o_a_quotient, 32'd0);
        check("mid_rst_b_err", 32'(o_b_err), 32'd0);
        check("mid_rst_b_flags", 32'(o_b_flags), 32'd0);
        tick();
        i_reset = 1'b0;
        repeat (12) tick();
        check("a_busy_after_late", 32'(o_a_busy), 32'd0);
        check("issue_queue_empty", 32'(iss_q.size()), 32'd0);

        // Normal service resumes after reset
        div_delay = 3;
        exp_iss(1'b0, 1'b0, 32'd9, 32'd3);
        exp_res(1'b0, 32'd3, 1'b0, 4'b0000, cyc, 6);
        put_a(1'b0, 32'd9, 32'd3);
        tick();
        clear_wr();
        wait_drain(60);
        check("results_all_seen", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
